// File: rtl/dm_bridge_pkg.sv
// Shared definitions for the data-memory bridge: FSM state encoding and
// the lane-select width used by the byte-lane helper.
package dm_bridge_pkg;

    localparam int LANE_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/byte_lane.sv
// Combinational byte-lane helper. Extracts a sign-extended byte from a
// little-endian word, and merges a byte into a word at the selected lane.
module byte_lane
    import dm_bridge_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [LANE_W-1:0] lane,
    input  logic [7:0]        byte_in,
    output logic [31:0]       ext,
    output logic [31:0]       merged
);

    logic [7:0] sel;

    // Lane 0 is bits [7:0]; the lane number times eight is the bit offset.
    assign sel = word[{lane, 3'b000} +: 8];
    assign ext = {{24{sel[7]}}, sel};

    // Each output lane takes the new byte when selected, else keeps the word.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = (lane == LANE_W'(gi)) ? byte_in : word[gi*8 +: 8];
        end
    endgenerate

endmodule

// File: rtl/dm_bridge.sv
// Data-memory bridge: turns a single load/store request from the core into
// valid/ready word transfers on a memory slave, with read-modify-write for
// byte stores and sign-extended byte loads. All outputs decode registered
// state or capture registers, so nothing combinationally follows req or m_ready.
module dm_bridge
    import dm_bridge_pkg::*;
#(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic          we,
    input  logic          bmode,
    input  logic [AW+1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          busy,
    output logic          m_valid,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_wdata,
    input  logic          m_ready,
    input  logic [31:0]   m_rdata
);

    state_t        state_reg, state_next;
    logic          we_reg, bmode_reg;
    logic [AW+1:0] addr_reg;
    logic [31:0]   wdata_reg;
    logic [31:0]   rd_word_reg;
    logic [31:0]   rdata_reg;

    logic          xfer;
    logic [31:0]   lane_word;
    logic [31:0]   lane_ext;
    logic [31:0]   lane_merged;

    assign xfer = m_valid && m_ready;

    // In RD the helper extracts from the live read data; in WR it merges
    // into the word captured by the preceding read.
    assign lane_word = (state_reg == ST_RD) ? m_rdata : rd_word_reg;

    byte_lane u_byte_lane (
        .word    (lane_word),
        .lane    (addr_reg[LANE_W-1:0]),
        .byte_in (wdata_reg[7:0]),
        .ext     (lane_ext),
        .merged  (lane_merged)
    );

    // Next-state logic: word stores skip the read, byte stores do both phases.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req) state_next = (we && !bmode) ? ST_WR : ST_RD;
            ST_RD:   if (xfer) state_next = (we_reg && bmode_reg) ? ST_WR : ST_DONE;
            ST_WR:   if (xfer) state_next = ST_DONE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register; the asynchronous reset aborts any transfer in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_reg <= ST_IDLE;
        else      state_reg <= state_next;
    end

    // Request capture in IDLE and read-data capture on the read transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_reg      <= 1'b0;
            bmode_reg   <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            rd_word_reg <= '0;
            rdata_reg   <= '0;
        end else begin
            if (state_reg == ST_IDLE && req) begin
                we_reg    <= we;
                bmode_reg <= bmode;
                addr_reg  <= addr;
                wdata_reg <= wdata;
            end
            if (state_reg == ST_RD && xfer) begin
                rd_word_reg <= m_rdata;
                // Only loads update the visible result; byte stores reuse RD too.
                if (!we_reg) rdata_reg <= bmode_reg ? lane_ext : m_rdata;
            end
        end
    end

    assign rdata   = rdata_reg;
    assign done    = (state_reg == ST_DONE);
    assign busy    = (state_reg != ST_IDLE);
    assign m_valid = (state_reg == ST_RD) || (state_reg == ST_WR);
    assign m_we    = (state_reg == ST_WR);
    assign m_addr  = addr_reg[AW+1:2];
    assign m_wdata = (state_reg == ST_WR) ? (bmode_reg ? lane_merged : wdata_reg) : 32'h0;

endmodule

// File: tb/tb_dm_bridge.sv
// Self-checking bench for dm_bridge: a behavioural memory slave with
// programmable wait states and a word-array reference model of the memory.
module tb_dm_bridge;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req = 1'b0;
    logic          we = 1'b0;
    logic          bmode = 1'b0;
    logic [AW+1:0] addr = '0;
    logic [31:0]   wdata = '0;
    logic [31:0]   rdata;
    logic          done, busy;
    logic          m_valid, m_we;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_wdata;
    logic          m_ready;
    logic [31:0]   m_rdata;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic        w;
        logic [9:0]  a;
        logic [31:0] d;
    } xfer_t;

    xfer_t       xfers[$];
    logic [31:0] mem[1024];
    logic [31:0] ref_mem[1024];
    logic [31:0] exp_rdata = 32'h0;
    int          stall_rd = 0;
    int          stall_wr = 0;
    int          wait_cnt = 0;

    always #5 clk = ~clk;

    dm_bridge #(.AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .we      (we),
        .bmode   (bmode),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .done    (done),
        .busy    (busy),
        .m_valid (m_valid),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_ready (m_ready),
        .m_rdata (m_rdata)
    );

    // Slave: ready after the programmed number of wait cycles per phase.
    assign m_ready = m_valid && (wait_cnt >= (m_we ? stall_wr : stall_rd));
    assign m_rdata = mem[m_addr];

    always @(posedge clk or negedge rst) begin
        if (!rst) wait_cnt <= 0;
        else if (m_valid && !m_ready) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    always @(posedge clk) begin
        if (rst && m_valid && m_ready) begin
            xfers.push_back('{w: m_we, a: m_addr, d: m_wdata});
            if (m_we) mem[m_addr] <= m_wdata;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sext_lane(input logic [31:0] w, input int lane);
        logic [31:0] b;
        b = (w >> (8 * lane)) & 32'hFF;
        return (b >= 32'h80) ? (b | 32'hFFFFFF00) : b;
    endfunction

    // One transaction; called at a falling edge, returns at the falling edge
    // of the idle cycle right after done so the next call can issue back-to-back.
    task automatic do_op(input logic op_we, input logic op_bm, input logic [11:0] op_addr,
                         input logic [31:0] op_wd, input int sr, input int sw,
                         input bit inject, input string name);
        int          nrd, nwr, exp_lat, k, lane;
        logic [9:0]  wa;
        logic [31:0] old_w, exp_wd;
        bit          seen;
        logic        pv, pr, pw;
        logic [9:0]  pa;
        logic [31:0] pd;
        wa    = op_addr[11:2];
        lane  = int'(op_addr[1:0]);
        old_w = ref_mem[wa];
        nrd   = (!op_we || op_bm) ? 1 : 0;
        nwr   = op_we ? 1 : 0;
        exp_lat = 1 + nrd * (1 + sr) + nwr * (1 + sw);
        exp_wd  = 32'h0;
        if (op_we) begin
            if (op_bm)
                exp_wd = (old_w & ~(32'hFF << (8 * lane))) | ({24'h0, op_wd[7:0]} << (8 * lane));
            else
                exp_wd = op_wd;
            ref_mem[wa] = exp_wd;
        end else begin
            exp_rdata = op_bm ? sext_lane(old_w, lane) : old_w;
        end
        stall_rd = sr;
        stall_wr = sw;
        xfers.delete();
        req = 1'b1; we = op_we; bmode = op_bm; addr = op_addr; wdata = op_wd;
        @(negedge clk);
        k = 1; seen = 1'b0; pv = 1'b0; pr = 1'b0; pw = 1'b0; pa = '0; pd = '0;
        while (1) begin
            req = 1'b0;
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy cycle %0d: got %b want 1", name, k, busy);
            end
            if (pv && !pr) begin
                checks++;
                if (m_valid !== 1'b1 || m_we !== pw || m_addr !== pa || m_wdata !== pd) begin
                    failures++;
                    $display("FAIL %s stall stability cycle %0d: got v=%b we=%b a=%h d=%h want v=1 we=%b a=%h d=%h",
                             name, k, m_valid, m_we, m_addr, m_wdata, pw, pa, pd);
                end
            end
            pv = m_valid; pr = m_ready; pw = m_we; pa = m_addr; pd = m_wdata;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            if (k >= 60) break;
            if (inject && ($urandom_range(1, 0) == 1)) begin
                req = 1'b1; we = 1'($urandom); bmode = 1'($urandom);
                addr = 12'($urandom); wdata = $urandom;
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (!seen || k != exp_lat) begin
            failures++;
            $display("FAIL %s latency: got %0d (seen=%b) want %0d", name, k, seen, exp_lat);
        end
        checks++;
        if (rdata !== exp_rdata) begin
            failures++;
            $display("FAIL %s rdata: got %h want %h", name, rdata, exp_rdata);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s after done: got done=%b busy=%b want 0 0", name, done, busy);
        end
        checks++;
        if (xfers.size() != nrd + nwr) begin
            failures++;
            $display("FAIL %s transfer count: got %0d want %0d", name, xfers.size(), nrd + nwr);
        end else begin
            if (nrd == 1) begin
                checks++;
                if (xfers[0].w !== 1'b0 || xfers[0].a !== wa) begin
                    failures++;
                    $display("FAIL %s read xfer: got we=%b a=%h want we=0 a=%h", name, xfers[0].w, xfers[0].a, wa);
                end
            end
            if (nwr == 1) begin
                checks++;
                if (xfers[nrd].w !== 1'b1 || xfers[nrd].a !== wa || xfers[nrd].d !== exp_wd) begin
                    failures++;
                    $display("FAIL %s write xfer: got we=%b a=%h d=%h want we=1 a=%h d=%h",
                             name, xfers[nrd].w, xfers[nrd].a, xfers[nrd].d, wa, exp_wd);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rdata !== 32'h0 || done !== 1'b0 || busy !== 1'b0 || m_valid !== 1'b0 ||
            m_we !== 1'b0 || m_addr !== '0 || m_wdata !== 32'h0) begin
            failures++;
            $display("FAIL reset values: got rdata=%h done=%b busy=%b v=%b we=%b a=%h d=%h want all 0",
                     rdata, done, busy, m_valid, m_we, m_addr, m_wdata);
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        do_op(1'b1, 1'b0, 12'h010, 32'h12345678, 0, 0, 1'b0, "word_store");
        checks++;
        if (mem[4] !== 32'h12345678) begin
            failures++;
            $display("FAIL word_store mem[4]: got %h want 12345678", mem[4]);
        end
        do_op(1'b0, 1'b0, 12'h010, 32'h0, 0, 0, 1'b0, "word_load");
        checks++;
        if (rdata !== 32'h12345678) begin
            failures++;
            $display("FAIL word_load const: got %h want 12345678", rdata);
        end
        do_op(1'b1, 1'b0, 12'h010, 32'h11223344, 0, 0, 1'b0, "word_store2");
        do_op(1'b1, 1'b1, 12'h012, 32'h000000AB, 0, 0, 1'b0, "byte_store");
        checks++;
        if (mem[4] !== 32'h11AB3344) begin
            failures++;
            $display("FAIL byte_store merged: got %h want 11ab3344", mem[4]);
        end
        do_op(1'b1, 1'b0, 12'h020, 32'h80FF0000, 0, 0, 1'b0, "store_80ff");
        do_op(1'b0, 1'b1, 12'h023, 32'h0, 0, 0, 1'b0, "byte_load_l3");
        checks++;
        if (rdata !== 32'hFFFFFF80) begin
            failures++;
            $display("FAIL byte_load_l3 const: got %h want ffffff80", rdata);
        end
        do_op(1'b0, 1'b1, 12'h022, 32'h0, 0, 0, 1'b0, "byte_load_l2");
        checks++;
        if (rdata !== 32'hFFFFFFFF) begin
            failures++;
            $display("FAIL byte_load_l2 const: got %h want ffffffff", rdata);
        end
        do_op(1'b1, 1'b0, 12'h030, 32'h0000007F, 0, 0, 1'b0, "store_7f");
        do_op(1'b0, 1'b1, 12'h030, 32'h0, 0, 0, 1'b0, "byte_load_l0");
        checks++;
        if (rdata !== 32'h0000007F) begin
            failures++;
            $display("FAIL byte_load_l0 const: got %h want 0000007f", rdata);
        end
    endtask

    task automatic test_stall();
        do_op(1'b1, 1'b1, 12'h011, 32'h0000005A, 3, 3, 1'b1, "stalled_byte_store");
        do_op(1'b0, 1'b0, 12'h010, 32'h0, 2, 0, 1'b1, "stalled_word_load");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 1'($urandom), {7'h0, 3'($urandom), 2'($urandom)}, $urandom,
                  int'($urandom_range(3, 0)), int'($urandom_range(3, 0)), 1'($urandom), "random_op");
        end
    endtask

    task automatic test_reset_abort();
        stall_rd = 0;
        stall_wr = 100;
        xfers.delete();
        req = 1'b1; we = 1'b1; bmode = 1'b0; addr = 12'h040; wdata = 32'hDEADBEEF;
        @(negedge clk);
        req = 1'b0;
        checks++;
        if (m_valid !== 1'b1 || m_we !== 1'b1) begin
            failures++;
            $display("FAIL abort setup: got v=%b we=%b want 1 1", m_valid, m_we);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort async drop: got v=%b busy=%b want 0 0", m_valid, busy);
        end
        exp_rdata = 32'h0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || m_valid !== 1'b0) begin
                failures++;
                $display("FAIL abort quiet cycle %0d: got done=%b v=%b want 0 0", i, done, m_valid);
            end
        end
        checks++;
        if (xfers.size() != 0 || mem[16] !== ref_mem[16]) begin
            failures++;
            $display("FAIL abort no write: got xfers=%0d mem=%h want 0 %h", xfers.size(), mem[16], ref_mem[16]);
        end
        do_op(1'b0, 1'b0, 12'h010, 32'h0, 0, 0, 1'b0, "load_after_abort");
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        @(negedge clk);
        test_reset();
        test_directed();
        test_stall();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dm_bridge.md
# dm_bridge

Data-memory bridge that sits directly downstream of the multi-cycle core's data port. Accepts one load/store request at a time (word or byte), drives a word-wide memory slave over a valid/ready handshake, performs read-modify-write for byte stores, and returns load data (byte loads sign-extended) with a one-cycle `done` pulse. Lets the core talk to memories with variable latency instead of the fixed single-cycle `dm_4k`.

## Interface
- `AW`, 10: word-address width of the memory slave; byte address width is `AW+2`.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req`  in  1  request strobe, sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `bmode`  in  1  1 = byte access, 0 = word access.
- `addr`  in  AW+2  byte address; `addr[1:0]` selects the lane for byte access and is ignored for word access.
- `wdata`  in  32  store data; a byte store uses `wdata[7:0]`.
- `rdata`  out  32  load result, valid from the `done` cycle and held until the next load completes.
- `done`  out  1  one-cycle completion pulse, for loads and stores.
- `busy`  out  1  high from the cycle after `req` is accepted through the `done` cycle.
- `m_valid`  out  1  memory request valid.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  AW  word address, `addr[AW+1:2]`.
- `m_wdata`  out  32  memory write data.
- `m_ready`  in  1  slave accepts; transfer occurs when `m_valid && m_ready`.
- `m_rdata`  in  32  read data, valid in the cycle of a read transfer.

## Operation
- States: IDLE, RD, WR, DONE.
- IDLE
  - If `req`, capture `we`, `bmode`, `addr` and `wdata`.
  - Next state is WR for a word store, otherwise RD (loads and byte stores).
- RD
  - Drives `m_valid=1`, `m_we=0` and holds both until `m_ready`.
  - On the transfer, captures `m_rdata`.
  - Next state is WR for a byte store, otherwise DONE.
- WR
  - Drives `m_valid=1`, `m_we=1` and holds until `m_ready`.
  - Write data: word store sends `wdata`; byte store sends the captured word with lane `addr[1:0]` replaced by `wdata[7:0]`.
  - Next state is DONE.
- DONE
  - Asserts `done=1` for one cycle.
  - For a load, `rdata` is the captured word (word access) or `{{24{b[7]}}, b}`, where `b` is lane `addr[1:0]`.
  - Next state is IDLE.
- Byte lanes are little-endian: lane 0 = bits [7:0], lane 3 = bits [31:24].
- `m_addr`, `m_we` and `m_wdata` are stable while `m_valid` is high. `m_valid` never drops before `m_ready`.
- `req` outside IDLE is ignored, with no queuing. The core holds `req` only as a single-cycle strobe.
- `rdata` is not updated by stores.

## Timing
- Reset values:
  - state IDLE;
  - `rdata=0`;
  - `done=0`, `busy=0`;
  - `m_valid=0`, `m_we=0`, `m_addr=0`, `m_wdata=0`.
- Reset mid-operation aborts immediately and asynchronously: `m_valid` falls without waiting for `m_ready`, and no `done` is produced.
- Latency with `m_ready` tied high, `req` in cycle N:
  - load (word or byte): `done` in N+2;
  - word store: `done` in N+2;
  - byte store: `done` in N+3.
- Each cycle `m_ready` is low in RD or WR adds one cycle.
- Back-to-back: the earliest next `req` is accepted in the cycle after `done`. Minimum request spacing is 3 cycles (4 for a byte store).
- `done` and `busy` are registered state decodes; no combinational path from `req` or `m_ready` to any output.

## Structure
- Shared package `dm_bridge_pkg` holds:
  - the state enum (IDLE=0, RD=1, WR=2, DONE=3);
  - the lane-select width constant (2).
- Sub-module `byte_lane` is combinational and does both lane operations:
  - extract: word + lane → sign-extended byte;
  - merge: word + lane + byte → merged word.
- The FSM and capture registers live in `dm_bridge`. Target is about 150–250 lines total.

## Test plan
- Word store, then word load, at `addr=0x010` with `wdata=0x12345678` and zero-wait slave:
  - `m_addr=4`;
  - `done` at N+2 for each;
  - `rdata=0x12345678`.
- Byte store at `addr=0x012` with `wdata=0xAB` over memory word `0x11223344`:
  - one read, then one write of `0x11AB3344`;
  - `done` at N+3.
- Byte load of lane 3 from `0x80FF0000`: `rdata=0xFFFFFF80`. Byte load of lane 2 from the same word: `rdata=0xFFFFFFFF`. Byte load of lane 0 from `0x0000007F`: `rdata=0x0000007F`.
- Slave with `m_ready` low for 3 cycles in both RD and WR during a byte store:
  - `m_valid`, `m_addr` and `m_wdata` stay stable;
  - `done` at N+9;
  - `req` pulses while busy are ignored.
- `rst` low while in WR with `m_ready=0`:
  - `m_valid` and `busy` drop asynchronously;
  - no `done`;
  - after release, a fresh word load completes normally.
